// File: rtl/infer_sched_pkg.sv
// Shared types and constants for the inference scheduler.
// The optional INFER_SCHED_PERF_EN build adds the latency monitor.
package infer_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        ARGMAX,
        PUSH
    } state_e;

    localparam logic [3:0] ERR_NUM         = 4'hF;
    localparam int         DEF_NUM_CLASSES = 10;
    localparam int         RES_W           = 5;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sched_res_fifo.sv
// Result FIFO; an extra pointer bit separates full from empty.
module sched_res_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= din;
            end
        end
    end

endmodule

// File: rtl/infer_sched.sv
// Single-image inference controller with timeout and result FIFO.
// Define INFER_SCHED_PERF_EN to add the last_latency output.
module infer_sched
    import infer_sched_pkg::*;
#(
    parameter int NUM_CLASSES    = DEF_NUM_CLASSES,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        GlobalReset,
    input  logic        Input_Valid,
    output logic        Input_Ready,
    output logic        layer_start,
    input  logic        cell_outputvalid,
    input  logic        am_valid,
    input  logic [3:0]  am_num,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_num,
    output logic        res_err,
    output logic        busy,
    output logic [15:0] img_count
`ifdef INFER_SCHED_PERF_EN
    ,
    output logic [15:0] last_latency
`endif
);

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0] NC = 5'(NUM_CLASSES);

    state_e      state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [3:0]  num_q, num_d;
    logic        err_q, err_d;
    logic        layer_start_q, layer_start_d;
    logic [15:0] img_count_q, img_count_d;

    logic             accept;
    logic             timeout;
    logic             bad_class;
    logic             fifo_empty;
    logic             fifo_full;
    logic [RES_W-1:0] fifo_dout;

    assign Input_Ready = (state_q == IDLE) && !fifo_full;
    assign accept      = Input_Valid && Input_Ready;
    assign timeout     = (cnt_q >= TMO_LAST);
    assign bad_class   = ({1'b0, am_num} >= NC);
    assign layer_start = layer_start_q;
    assign busy        = (state_q != IDLE);
    assign img_count   = img_count_q;
    assign res_valid   = !fifo_empty;
    assign res_num     = fifo_dout[4:1];
    assign res_err     = fifo_dout[0];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        num_d         = num_q;
        err_d         = err_q;
        layer_start_d = 1'b0;
        img_count_d   = img_count_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d       = COMPUTE;
                    cnt_d         = '0;
                    layer_start_d = 1'b1;
                end
            end
            COMPUTE: begin
                cnt_d = timeout ? cnt_q : cnt_q + 1'b1;
                if (cell_outputvalid) begin
                    state_d = ARGMAX;
                end else if (timeout) begin
                    state_d = PUSH;
                    num_d   = ERR_NUM;
                    err_d   = 1'b1;
                end
            end
            ARGMAX: begin
                cnt_d = timeout ? cnt_q : cnt_q + 1'b1;
                // A result arriving on the timeout cycle still counts.
                if (am_valid) begin
                    state_d = PUSH;
                    num_d   = bad_class ? ERR_NUM : am_num;
                    err_d   = bad_class;
                end else if (timeout) begin
                    state_d = PUSH;
                    num_d   = ERR_NUM;
                    err_d   = 1'b1;
                end
            end
            PUSH: begin
                state_d     = IDLE;
                img_count_d = img_count_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            num_q         <= '0;
            err_q         <= 1'b0;
            layer_start_q <= 1'b0;
            img_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            num_q         <= num_d;
            err_q         <= err_d;
            layer_start_q <= layer_start_d;
            img_count_q   <= img_count_d;
        end
    end

    sched_res_fifo #(
        .WIDTH(RES_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(GlobalReset),
        .push (state_q == PUSH),
        .din  ({num_q, err_q}),
        .pop  (res_valid && res_ready),
        .dout (fifo_dout),
        .empty(fifo_empty),
        .full (fifo_full)
    );

`ifdef INFER_SCHED_PERF_EN
    logic [15:0] lat_q, lat_d;
    logic [15:0] last_lat_q, last_lat_d;

    assign last_latency = last_lat_q;

    always_comb begin
        lat_d      = lat_q;
        last_lat_d = last_lat_q;
        if (accept) begin
            lat_d = '0;
        end else if (state_q == COMPUTE || state_q == ARGMAX) begin
            lat_d = sat_inc16(lat_q);
        end
        if (state_q == PUSH) begin
            last_lat_d = sat_inc16(lat_q);
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            lat_q      <= '0;
            last_lat_q <= '0;
        end else begin
            lat_q      <= lat_d;
            last_lat_q <= last_lat_d;
        end
    end
`endif

endmodule

// File: tb/tb_infer_sched.sv
// Scoreboard bench for infer_sched (TIMEOUT_CYCLES=20, FIFO_DEPTH=4).
module tb_infer_sched;

    logic        clk = 1'b0;
    logic        GlobalReset;
    logic        Input_Valid;
    logic        Input_Ready;
    logic        layer_start;
    logic        cell_outputvalid;
    logic        am_valid;
    logic [3:0]  am_num;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_num;
    logic        res_err;
    logic        busy;
    logic [15:0] img_count;
`ifdef INFER_SCHED_PERF_EN
    logic [15:0] last_latency;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    logic [4:0] exp_q[$];
    logic [4:0] exp_r;

    always #5 clk = ~clk;

    infer_sched #(
        .NUM_CLASSES(10),
        .TIMEOUT_CYCLES(20),
        .FIFO_DEPTH(4)
    ) dut (
        .clk             (clk),
        .GlobalReset     (GlobalReset),
        .Input_Valid     (Input_Valid),
        .Input_Ready     (Input_Ready),
        .layer_start     (layer_start),
        .cell_outputvalid(cell_outputvalid),
        .am_valid        (am_valid),
        .am_num          (am_num),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_num         (res_num),
        .res_err         (res_err),
        .busy            (busy),
        .img_count       (img_count)
`ifdef INFER_SCHED_PERF_EN
        ,
        .last_latency    (last_latency)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic accept();
        Input_Valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (Input_Ready) break;
            step();
        end
        checks++;
        if (Input_Ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_wait Input_Ready=%b want 1", Input_Ready);
        end
        step();
        Input_Valid = 1'b0;
        t0 = cyc;
    endtask

    task automatic pulse_cov(input int k);
        while (cyc < t0 + k - 1) step();
        cell_outputvalid = 1'b1;
        step();
        cell_outputvalid = 1'b0;
    endtask

    task automatic pulse_am(input int k, input logic [3:0] n);
        while (cyc < t0 + k - 1) step();
        am_num = n;
        am_valid = 1'b1;
        step();
        am_valid = 1'b0;
    endtask

    task automatic test_reset();
        GlobalReset = 1'b0;
        Input_Valid = 1'b0;
        cell_outputvalid = 1'b0;
        am_valid = 1'b0;
        am_num = 4'd0;
        res_ready = 1'b1;
        step();
        step();
        checks++;
        if ({busy, res_valid, res_num, res_err, layer_start} !== 8'b0) begin
            failures++;
            $display("FAIL reset_state busy=%b vld=%b num=%h err=%b ls=%b want all 0",
                     busy, res_valid, res_num, res_err, layer_start);
        end
        checks++;
        if (img_count !== 16'd0 || Input_Ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cnt img=%0d rdy=%b want 0 1", img_count, Input_Ready);
        end
        GlobalReset = 1'b1;
        step();
    endtask

    task automatic test_normal();
        exp_q.push_back({4'd7, 1'b0});
        accept();
        checks++;
        if (layer_start !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_pulse ls=%b busy=%b want 1 1", layer_start, busy);
        end
        step();
        checks++;
        if (layer_start !== 1'b0) begin
            failures++;
            $display("FAIL start_width ls=%b want 0", layer_start);
        end
        pulse_am(3, 4'd2);
        pulse_cov(5);
        pulse_cov(8);
        pulse_am(12, 4'd7);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL push_cycle vld=%b busy=%b want 0 1", res_valid, busy);
        end
        step();
        exp_r = exp_q.pop_front();
        checks++;
        if ({res_valid, res_num, res_err} !== {1'b1, exp_r}) begin
            failures++;
            $display("FAIL normal_res vld=%b num=%h err=%b want 1 %h %b",
                     res_valid, res_num, res_err, exp_r[4:1], exp_r[0]);
        end
        checks++;
        if (img_count !== 16'd1) begin
            failures++;
            $display("FAIL normal_cnt img=%0d want 1", img_count);
        end
`ifdef INFER_SCHED_PERF_EN
        checks++;
        if (last_latency !== 16'd13) begin
            failures++;
            $display("FAIL latency got %0d want 13", last_latency);
        end
`endif
        step();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL normal_drain vld=%b busy=%b want 0 0", res_valid, busy);
        end
    endtask

    task automatic test_timeout();
        exp_q.push_back({4'hF, 1'b1});
        accept();
        while (cyc < t0 + 20) step();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL tmo_push_cycle vld=%b busy=%b want 0 1", res_valid, busy);
        end
        step();
        exp_r = exp_q.pop_front();
        checks++;
        if ({res_valid, res_num, res_err} !== {1'b1, exp_r}) begin
            failures++;
            $display("FAIL tmo_res vld=%b num=%h err=%b want 1 %h %b",
                     res_valid, res_num, res_err, exp_r[4:1], exp_r[0]);
        end
        checks++;
        if (busy !== 1'b0 || img_count !== 16'd2) begin
            failures++;
            $display("FAIL tmo_idle busy=%b img=%0d want 0 2", busy, img_count);
        end
        step();
    endtask

    task automatic test_bad_class();
        exp_q.push_back({4'hF, 1'b1});
        accept();
        pulse_cov(2);
        pulse_am(4, 4'd12);
        for (int i = 0; i < 50; i++) begin
            if (res_valid) break;
            step();
        end
        exp_r = exp_q.pop_front();
        checks++;
        if ({res_valid, res_num, res_err} !== {1'b1, exp_r}) begin
            failures++;
            $display("FAIL bad_class vld=%b num=%h err=%b want 1 %h %b",
                     res_valid, res_num, res_err, exp_r[4:1], exp_r[0]);
        end
        checks++;
        if (img_count !== 16'd3) begin
            failures++;
            $display("FAIL bad_cnt img=%0d want 3", img_count);
        end
        step();
    endtask

    task automatic test_timeout_tie();
        exp_q.push_back({4'd3, 1'b0});
        accept();
        pulse_cov(5);
        pulse_am(20, 4'd3);
        step();
        exp_r = exp_q.pop_front();
        checks++;
        if ({res_valid, res_num, res_err} !== {1'b1, exp_r}) begin
            failures++;
            $display("FAIL tie_res vld=%b num=%h err=%b want 1 %h %b",
                     res_valid, res_num, res_err, exp_r[4:1], exp_r[0]);
        end
        checks++;
        if (img_count !== 16'd4) begin
            failures++;
            $display("FAIL tie_cnt img=%0d want 4", img_count);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int pops;
        res_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            exp_q.push_back({4'(n), 1'b0});
            accept();
            pulse_cov(1);
            pulse_am(2, 4'(n));
        end
        step();
        Input_Valid = 1'b1;
        step();
        checks++;
        if (Input_Ready !== 1'b0 || res_valid !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL full_block rdy=%b vld=%b busy=%b want 0 1 0",
                     Input_Ready, res_valid, busy);
        end
        res_ready = 1'b1;
        exp_r = exp_q.pop_front();
        checks++;
        if ({res_num, res_err} !== exp_r) begin
            failures++;
            $display("FAIL full_head num=%h err=%b want %h %b",
                     res_num, res_err, exp_r[4:1], exp_r[0]);
        end
        step();
        res_ready = 1'b0;
        checks++;
        if (Input_Ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_pop rdy=%b want 1", Input_Ready);
        end
        Input_Valid = 1'b0;
        exp_q.push_back({4'd9, 1'b0});
        accept();
        pulse_cov(1);
        pulse_am(2, 4'd9);
        res_ready = 1'b1;
        exp_r = exp_q.pop_front();
        checks++;
        if ({res_num, res_err} !== exp_r) begin
            failures++;
            $display("FAIL pp_head num=%h err=%b want %h %b",
                     res_num, res_err, exp_r[4:1], exp_r[0]);
        end
        step();
        res_ready = 1'b0;
        checks++;
        if (Input_Ready !== 1'b1 || res_valid !== 1'b1) begin
            failures++;
            $display("FAIL push_pop_same rdy=%b vld=%b want 1 1", Input_Ready, res_valid);
        end
        res_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            if (!res_valid || exp_q.size() == 0) break;
            exp_r = exp_q.pop_front();
            checks++;
            if ({res_num, res_err} !== exp_r) begin
                failures++;
                $display("FAIL drain_%0d num=%h err=%b want %h %b",
                         i, res_num, res_err, exp_r[4:1], exp_r[0]);
            end
            pops++;
            step();
        end
        checks++;
        if (pops != 3 || exp_q.size() != 0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_count pops=%0d left=%0d vld=%b want 3 0 0",
                     pops, exp_q.size(), res_valid);
        end
        checks++;
        if (img_count !== 16'd9) begin
            failures++;
            $display("FAIL b2b_cnt img=%0d want 9", img_count);
        end
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b1;
        accept();
        pulse_cov(3);
        step();
        step();
        GlobalReset = 1'b0;
        #1;
        checks++;
        if ({busy, res_valid, layer_start} !== 3'b0 || img_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid busy=%b vld=%b ls=%b img=%0d want 0 0 0 0",
                     busy, res_valid, layer_start, img_count);
        end
        step();
        GlobalReset = 1'b1;
        step();
        am_num = 4'd5;
        am_valid = 1'b1;
        step();
        am_valid = 1'b0;
        cell_outputvalid = 1'b1;
        step();
        cell_outputvalid = 1'b0;
        repeat (3) step();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || img_count !== 16'd0) begin
            failures++;
            $display("FAIL late_am vld=%b busy=%b img=%0d want 0 0 0",
                     res_valid, busy, img_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_bad_class();
        test_timeout_tie();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/infer_sched.md
INFER_SCHED -- requirements
Module: infer_sched

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10, number of valid class indices (0..NUM_CLASSES-1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023, maximum cycles from image accept to argmax result.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 GlobalReset  in  1  asynchronous active-low reset.
REQ-007 Input_Valid  in  1  upstream offers an image.
REQ-008 Input_Ready  out  1  controller accepts the image this cycle.
REQ-009 layer_start  out  1  one-cycle pulse starting the neuron-cell datapath.
REQ-010 cell_outputvalid  in  1  cell datapath scores ready.
REQ-011 am_valid  in  1  argmax result valid (one-cycle pulse).
REQ-012 am_num  in  4  argmax class index.
REQ-013 res_valid  out  1  result FIFO non-empty.
REQ-014 res_ready  in  1  downstream pops the head entry.
REQ-015 res_num  out  4  head class index.
REQ-016 res_err  out  1  head entry is a timeout or out-of-range error.
REQ-017 busy  out  1  an image is in flight (state not IDLE).
REQ-018 img_count  out  16  results pushed since reset, wraps at 65535->0.

Function
REQ-019 FSM SHALL have states IDLE, COMPUTE, ARGMAX, PUSH; one image in flight at most.
REQ-020 Input_Ready SHALL be combinational: state==IDLE and FIFO not full.
REQ-021 On Input_Valid&&Input_Ready: IDLE->COMPUTE, registered layer_start high for exactly the next cycle, timeout counter cleared to 0.
REQ-022 COMPUTE->ARGMAX on cell_outputvalid; ARGMAX->PUSH on am_valid, capturing am_num.
REQ-023 Timeout counter SHALL increment each cycle in COMPUTE/ARGMAX; on reaching TIMEOUT_CYCLES go to PUSH with error, num=4'hF.
REQ-024 Valid event (cell_outputvalid/am_valid) in the same cycle as timeout SHALL win over timeout.
REQ-025 am_num >= NUM_CLASSES SHALL be pushed as num=4'hF, err=1.
REQ-026 PUSH SHALL write {num,err} to FIFO, increment img_count, return to IDLE in one cycle; accept-to-push latency = computation cycles + 2.
REQ-027 Push SHALL never find FIFO full (guaranteed by REQ-020); no overflow path required.
REQ-028 Pop on res_valid&&res_ready; simultaneous push and pop SHALL keep occupancy unchanged and both succeed.
REQ-029 cell_outputvalid outside COMPUTE and am_valid outside ARGMAX SHALL be ignored.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty from an extra pointer bit.

Reset
REQ-031 Reset SHALL force state IDLE, layer_start=0, busy=0, FIFO empty (res_valid=0), res_num=0, res_err=0, img_count=0, timeout counter=0.
REQ-032 Reset mid-operation SHALL abandon the in-flight image with no result pushed.

Configuration
REQ-033 Macro INFER_SCHED_PERF_EN defined: add output last_latency[15:0], cycles from accept to push of the latest result, saturating at 16'hFFFF, reset 0.
REQ-034 Without INFER_SCHED_PERF_EN: port and counter absent; all other behaviour identical.

Structure
REQ-035 Package infer_sched_pkg SHALL hold the state typedef, ERR_NUM=4'hF and the default NUM_CLASSES constant.
REQ-036 FIFO SHALL be sub-module sched_res_fifo (parameterized width/depth, asynchronous active-low reset).

Verification
REQ-037 Accept image, cell_outputvalid 5 cycles later, am_valid{am_num=7} 12 cycles later, res_ready=1 -> res_valid with res_num=7, res_err=0, img_count=1.
REQ-038 Accept, no cell_outputvalid, TIMEOUT_CYCLES=20 -> res_num=4'hF, res_err=1 after timeout, FSM IDLE.
REQ-039 am_num=12 -> res_num=4'hF, res_err=1.
REQ-040 res_ready=0, 4 images completed -> Input_Ready=0 with Input_Valid high; one pop -> Input_Ready=1 next cycle.
REQ-041 Reset asserted in ARGMAX -> busy=0, res_valid=0 immediately; late am_valid ignored.
REQ-042 am_valid on the exact timeout cycle with am_num=3 -> res_num=3, res_err=0.
